pe_col_dispatch: RTL



---
 rtl/diff_demo_pkg.sv | 15 +
 rtl/pe_col_dispatch.sv | 117 +++++++++++
 2 files changed

// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the PE column dispatch path.
// GUARD_W is also used by the PE column controller.
package diff_demo_pkg;

   localparam int GUARD_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_FIN,
      DONE
   } dispatch_state_t;

endpackage

// File: rtl/pe_col_dispatch.sv
// Issues one guard-map control packet per column group to the PE column, one outstanding at a time.
// Optional macro DISPATCH_SKIP_ZERO_EN: drop all-zero guard maps (2-bit mode, not end-of-row) in FETCH.
module pe_col_dispatch
   import diff_demo_pkg::*;
#(
   parameter int ROW_W = 8,
   parameter int COL_W = 8,
   parameter int CNT_W = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ROW_W-1:0]   num_rows,
   input  logic [COL_W-1:0]   num_cols,
   input  logic               bit_mode_i,
   input  logic               kernel_mode_i,
   output logic               busy,
   output logic               done,
   input  logic               guard_valid,
   output logic               guard_ready,
   input  logic [GUARD_W-1:0] guard_map_in,
   output logic               ctrl_valid,
   input  logic               ctrl_ready,
   input  logic               ctrl_finish,
   output logic [GUARD_W-1:0] guard_map_o,
   output logic               bit_mode_o,
   output logic               kernel_mode_o,
   output logic               is_odd_row_o,
   output logic               end_of_row_o,
   output logic [CNT_W-1:0]   issue_cnt
);

   dispatch_state_t  state, state_next;
   logic [ROW_W-1:0] rows_cfg, row_cnt;
   logic [COL_W-1:0] cols_cfg, col_cnt;
   logic             bit_mode_cfg, kernel_mode_cfg;
   logic             last_col, last_row;
   logic             guard_take, issue_take, skip_zero, advance;

   assign last_col   = (col_cnt == cols_cfg - COL_W'(1));
   assign last_row   = (row_cnt == rows_cfg - ROW_W'(1));
   assign guard_take = guard_valid && guard_ready;
   assign issue_take = ctrl_valid && ctrl_ready;

`ifdef DISPATCH_SKIP_ZERO_EN
   // End-of-row maps are always issued so the PE still sees the row terminator.
   assign skip_zero = (guard_map_in == '0) && !bit_mode_cfg && !last_col;
`else
   assign skip_zero = 1'b0;
`endif

   assign advance     = ((state == WAIT_FIN) && ctrl_finish) || (guard_take && skip_zero);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign guard_ready = (state == FETCH);
   assign ctrl_valid  = (state == ISSUE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = (num_rows == '0 || num_cols == '0) ? DONE : FETCH;
         FETCH:    if (guard_take && !skip_zero) state_next = ISSUE;
         ISSUE:    if (issue_take) state_next = WAIT_FIN;
         WAIT_FIN: if (ctrl_finish) state_next = (last_col && last_row) ? DONE : FETCH;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rows_cfg        <= '0;
         cols_cfg        <= '0;
         bit_mode_cfg    <= 1'b0;
         kernel_mode_cfg <= 1'b0;
         row_cnt         <= '0;
         col_cnt         <= '0;
         issue_cnt       <= '0;
         guard_map_o     <= '0;
         bit_mode_o      <= 1'b0;
         kernel_mode_o   <= 1'b0;
         is_odd_row_o    <= 1'b0;
         end_of_row_o    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            rows_cfg        <= num_rows;
            cols_cfg        <= num_cols;
            bit_mode_cfg    <= bit_mode_i;
            kernel_mode_cfg <= kernel_mode_i;
            row_cnt         <= '0;
            col_cnt         <= '0;
            issue_cnt       <= '0;
         end
         if (advance) begin
            if (last_col) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + ROW_W'(1);
            end else begin
               col_cnt <= col_cnt + COL_W'(1);
            end
         end
         // Row index 0 is the first (odd) row; 4-bit mode always uses a dense map.
         if (guard_take && !skip_zero) begin
            guard_map_o   <= bit_mode_cfg ? '1 : guard_map_in;
            bit_mode_o    <= bit_mode_cfg;
            kernel_mode_o <= kernel_mode_cfg;
            is_odd_row_o  <= ~row_cnt[0];
            end_of_row_o  <= last_col;
         end
         if (issue_take && issue_cnt != '1)
            issue_cnt <= issue_cnt + CNT_W'(1);
      end
   end

endmodule
